refill_arbiter: RTL and testbench

//  Shares the single external refill port (req/ack/valid/data/c_addr) between the

---
 rtl/refill_arbiter_pkg.sv | 19 +
 rtl/refill_arbiter_rr_arb2.sv | 26 ++
 rtl/refill_arbiter.sv | 124 ++++++++++++
 tb/tb_refill_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/refill_arbiter_pkg.sv
// Shared definitions for the refill arbiter and the two cache miss controllers
// that sit in front of it: FSM encodings, grant codes and default geometry.
package refill_arbiter_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Port ownership: 0 = icache, 1 = dcache.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/refill_arbiter_rr_arb2.sv
// Two-way round-robin picker. req[0] is the icache, req[1] the dcache.
// When both request, the one that did not own the last fill wins.
module rr_arb2
  import refill_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  assign any = |req;

  // Pick the winner; a lone requester always wins, a tie goes against last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and a latch is never inferred.
    gnt = GNT_I;
    case (req)
      2'b10:   gnt = GNT_D;
      2'b11:   gnt = (last == GNT_D) ? GNT_I : GNT_D;
      default: gnt = GNT_I;
    endcase
  end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one external refill port between the icache and dcache miss
// controllers. One line fill at a time: IDLE picks a requester, REQ presents
// its address to memory until accepted, XFER routes LINE_WORDS beats back.
module refill_arbiter
  import refill_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ack,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              grant_d,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  state_e             state_q,     state_d;
  logic [ADDR_W-1:0]  m_addr_q,    m_addr_d;
  logic               grant_d_q,   grant_d_d;
  logic               rr_last_q,   rr_last_d;
  logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
  logic               proto_err_q, proto_err_d;

  logic pick_d;
  logic pick_any;

  rr_arb2 u_rr_arb2 (
    .req  ({d_req, i_req}),
    .last (rr_last_q),
    .gnt  (pick_d),
    .any  (pick_any)
  );

  // Next-state logic for the fill sequence, grant, address and beat counter.
  always_comb begin
    state_d     = state_q;
    m_addr_d    = m_addr_q;
    grant_d_d   = grant_d_q;
    rr_last_d   = rr_last_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q | (m_valid & (state_q != ST_XFER));
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          m_addr_d  = (pick_d == GNT_D) ? d_addr : i_addr;
          grant_d_d = pick_d;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Requests are not looked at here: a dropped req cannot abort the fill.
        if (m_ack) begin
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (m_valid) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            rr_last_d = grant_d_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any fill and hands the first tie to the icache.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      m_addr_q    <= '0;
      grant_d_q   <= GNT_I;
      rr_last_q   <= GNT_D;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      m_addr_q    <= m_addr_d;
      grant_d_q   <= grant_d_d;
      rr_last_q   <= rr_last_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Outputs decode registered state only; req inputs never reach them directly.
  assign m_req     = (state_q == ST_REQ);
  assign busy      = (state_q != ST_IDLE);
  assign m_addr    = m_addr_q;
  assign grant_d   = grant_d_q;
  assign proto_err = proto_err_q;

  assign i_ack   = m_ack & m_req & (grant_d_q == GNT_I);
  assign d_ack   = m_ack & m_req & (grant_d_q == GNT_D);
  assign i_valid = m_valid & (state_q == ST_XFER) & (grant_d_q == GNT_I);
  assign d_valid = m_valid & (state_q == ST_XFER) & (grant_d_q == GNT_D);
  assign i_data  = m_data;
  assign d_data  = m_data;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: each scenario task drives the caches and
// the memory side, then compares outputs against hand-computed values.
module tb_refill_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_ack, i_valid, d_ack, d_valid;
  logic [DW-1:0] i_data, d_data;
  logic          m_req;
  logic [AW-1:0] m_addr;
  logic          m_ack, m_valid;
  logic [DW-1:0] m_data;
  logic          busy, grant_d, proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_ack     (d_ack),
    .d_valid   (d_valid),
    .d_data    (d_data),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_ack     (m_ack),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .busy      (busy),
    .grant_d   (grant_d),
    .proto_err (proto_err)
  );

  always #5 hclk = ~hclk;

  // Hold reset for two cycles; returns at a falling edge with reset released.
  task automatic apply_reset();
    @(negedge hclk);
    hreset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; m_valid = 1'b0;
    repeat (2) @(negedge hclk);
    hreset = 1'b0;
  endtask

  // Memory-side model of one line fill: waits (bounded) for m_req, accepts it,
  // returns LW beats AAAA0000+n with 'gap' idle cycles before each, and tallies
  // what the caches saw. Returns at the falling edge after the last beat.
  task automatic serve_fill(input int ack_hold, input int gap, input bit drop_on_ack,
                            output int ack_i, output int ack_d,
                            output int val_i, output int val_d,
                            output int data_err, output int req_extra,
                            output logic gnt, output logic [AW-1:0] addr,
                            output bit found);
    int waited = 0;
    int total;
    int next_beat;
    int beat = 0;
    logic [DW-1:0] exp_data = '0;
    ack_i = 0; ack_d = 0; val_i = 0; val_d = 0; data_err = 0; req_extra = 0;
    gnt = 1'bx; addr = 'x; found = 1'b0;
    #1;
    while (m_req !== 1'b1 && waited < 10) begin
      @(negedge hclk);
      #1;
      waited++;
    end
    if (m_req !== 1'b1) return;
    found = 1'b1;
    gnt   = grant_d;
    addr  = m_addr;
    total     = 1 + (gap + 1) * LW;
    next_beat = 1 + gap;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge hclk);
      m_ack = (c < ack_hold);
      if (c == next_beat) begin
        exp_data = 32'hAAAA0000 + 32'(beat);
        m_valid  = 1'b1;
        m_data   = exp_data;
      end else begin
        m_valid = 1'b0;
        m_data  = 32'h5555_5555;
      end
      #1;
      ack_i += int'(i_ack);
      ack_d += int'(d_ack);
      val_i += int'(i_valid);
      val_d += int'(d_valid);
      if ((i_valid === 1'b1 || d_valid === 1'b1) && (i_data !== exp_data || d_data !== exp_data))
        data_err++;
      if (c > 0 && m_req !== 1'b0) req_extra++;
      if (c == 0 && drop_on_ack) begin
        if (i_ack === 1'b1) i_req = 1'b0;
        if (d_ack === 1'b1) d_req = 1'b0;
      end
      if (c == next_beat) begin
        beat++;
        next_beat += gap + 1;
      end
    end
    @(negedge hclk);
    m_ack   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge hclk);
    hreset = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 20'h12345; d_addr = 20'h6789A;
    m_ack = 1'b1; m_valid = 1'b1; m_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (m_req !== 1'b0) $display("FAIL reset_m_req got %b want 0", m_req); else n_pass++;
    n_checks++; if (m_addr !== 20'h0) $display("FAIL reset_m_addr got %h want 00000", m_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (grant_d !== 1'b0) $display("FAIL reset_grant_d got %b want 0", grant_d); else n_pass++;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got %b want 0", proto_err); else n_pass++;
    n_checks++; if ({i_ack, d_ack, i_valid, d_valid} !== 4'b0000)
      $display("FAIL reset_ack_valid got %b want 0000", {i_ack, d_ack, i_valid, d_valid}); else n_pass++;
    repeat (2) @(negedge hclk);
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; m_valid = 1'b0;
    hreset = 1'b0;
  endtask

  task automatic test_single_icache();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    @(negedge hclk);
    i_req = 1'b1; i_addr = 20'h00400; d_req = 1'b0;
    @(negedge hclk);
    #1;
    n_checks++; if (m_req !== 1'b1) $display("FAIL single_m_req_plus1 got %b want 1", m_req); else n_pass++;
    n_checks++; if (m_addr !== 20'h00400) $display("FAIL single_m_addr got %h want 00400", m_addr); else n_pass++;
    serve_fill(1, 0, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (f !== 1'b1) $display("FAIL single_found got %b want 1", f); else n_pass++;
    n_checks++; if (ai !== 1 || ad !== 0) $display("FAIL single_acks got i=%0d d=%0d want i=1 d=0", ai, ad); else n_pass++;
    n_checks++; if (vi !== 4 || vd !== 0) $display("FAIL single_valids got i=%0d d=%0d want i=4 d=0", vi, vd); else n_pass++;
    n_checks++; if (de !== 0) $display("FAIL single_data got %0d bad beats want 0", de); else n_pass++;
    n_checks++; if (rx !== 0) $display("FAIL single_m_req_drop got %0d extra cycles want 0", rx); else n_pass++;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_tie_after_reset();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    apply_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 20'h01230; d_addr = 20'hBEEF0;
    serve_fill(1, 0, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (g !== 1'b0 || a !== 20'h01230)
      $display("FAIL tie_first got gnt=%b addr=%h want gnt=0 addr=01230", g, a); else n_pass++;
    n_checks++; if (vi !== 4 || ad !== 0) $display("FAIL tie_first_counts got vi=%0d ad=%0d want vi=4 ad=0", vi, ad); else n_pass++;
    #1;
    n_checks++; if (m_req !== 1'b0) $display("FAIL tie_gap_t1 got m_req=%b want 0", m_req); else n_pass++;
    @(negedge hclk);
    #1;
    n_checks++; if (m_req !== 1'b1 || grant_d !== 1'b1 || m_addr !== 20'hBEEF0)
      $display("FAIL tie_second_t2 got m_req=%b grant_d=%b addr=%h want 1 1 beef0", m_req, grant_d, m_addr); else n_pass++;
    serve_fill(1, 0, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (g !== 1'b1 || ad !== 1 || ai !== 0 || vd !== 4 || vi !== 0)
      $display("FAIL tie_second_fill got gnt=%b ad=%0d ai=%0d vd=%0d vi=%0d want 1 1 0 4 0", g, ad, ai, vd, vi); else n_pass++;
  endtask

  task automatic test_alternate();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    logic [3:0] gnts;
    logic [3:0] vld_ok;
    apply_reset();
    i_req = 1'b1; d_req = 1'b1; i_addr = 20'h11110; d_addr = 20'h22220;
    for (int k = 0; k < 4; k++) begin
      serve_fill(1, 0, 1'b0, ai, ad, vi, vd, de, rx, g, a, f);
      gnts[k]   = g;
      vld_ok[k] = (g === 1'b0) ? (vi == 4 && vd == 0 && a === 20'h11110)
                               : (vd == 4 && vi == 0 && a === 20'h22220);
      if (k == 3) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    n_checks++; if (gnts !== 4'b1010) $display("FAIL alt_grants got %b want 1010 (fill0 in bit0)", gnts); else n_pass++;
    n_checks++; if (vld_ok !== 4'b1111) $display("FAIL alt_routing got %b want 1111", vld_ok); else n_pass++;
  endtask

  task automatic test_gaps_long_ack();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    @(negedge hclk);
    d_req = 1'b1; d_addr = 20'h5A5A5;
    serve_fill(5, 3, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (ad !== 1 || ai !== 0) $display("FAIL gaps_acks got d=%0d i=%0d want d=1 i=0", ad, ai); else n_pass++;
    n_checks++; if (vd !== 4 || vi !== 0) $display("FAIL gaps_valids got d=%0d i=%0d want d=4 i=0", vd, vi); else n_pass++;
    n_checks++; if (de !== 0 || a !== 20'h5A5A5) $display("FAIL gaps_data got errs=%0d addr=%h want 0 5a5a5", de, a); else n_pass++;
    #1;
    n_checks++; if (busy !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL gaps_end got busy=%b proto_err=%b want 0 0", busy, proto_err); else n_pass++;
  endtask

  task automatic test_proto_err();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    @(negedge hclk);
    m_valid = 1'b1; m_ack = 1'b1; m_data = 32'h0BAD_0BAD;
    #1;
    n_checks++; if ({i_valid, d_valid, i_ack, d_ack} !== 4'b0000)
      $display("FAIL idle_pulse_outputs got %b want 0000", {i_valid, d_valid, i_ack, d_ack}); else n_pass++;
    @(negedge hclk);
    m_valid = 1'b0; m_ack = 1'b0;
    #1;
    n_checks++; if (proto_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL proto_set got proto_err=%b busy=%b want 1 0", proto_err, busy); else n_pass++;
    i_req = 1'b1; i_addr = 20'h00800;
    serve_fill(1, 0, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (vi !== 4 || proto_err !== 1'b1)
      $display("FAIL proto_sticky got vi=%0d proto_err=%b want 4 1", vi, proto_err); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    int ai, ad, vi, vd, de, rx; logic g; logic [AW-1:0] a; bit f;
    apply_reset();
    #1;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL rst_clears_proto got %b want 0", proto_err); else n_pass++;
    @(negedge hclk);
    i_req = 1'b1; i_addr = 20'h00400; d_req = 1'b0;
    @(negedge hclk);
    m_ack = 1'b1;
    @(negedge hclk);
    m_ack = 1'b0; i_req = 1'b0; d_req = 1'b1; d_addr = 20'hD0D00;
    for (int b = 0; b < 2; b++) begin
      m_valid = 1'b1;
      m_data  = 32'hAAAA0000 + 32'(b);
      @(negedge hclk);
    end
    m_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_fill_busy got %b want 1", busy); else n_pass++;
    hreset = 1'b1;
    #1;
    n_checks++; if (m_req !== 1'b0 || busy !== 1'b0 || grant_d !== 1'b0)
      $display("FAIL mid_reset got m_req=%b busy=%b grant_d=%b want 0 0 0", m_req, busy, grant_d); else n_pass++;
    @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    #1;
    n_checks++; if (m_req !== 1'b1 || grant_d !== 1'b1 || m_addr !== 20'hD0D00)
      $display("FAIL post_reset_d got m_req=%b grant_d=%b addr=%h want 1 1 d0d00", m_req, grant_d, m_addr); else n_pass++;
    serve_fill(1, 0, 1'b1, ai, ad, vi, vd, de, rx, g, a, f);
    n_checks++; if (vd !== 4 || vi !== 0 || ad !== 1)
      $display("FAIL post_reset_fill got vd=%0d vi=%0d ad=%0d want 4 0 1", vd, vi, ad); else n_pass++;
  endtask

  initial begin
    hreset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    m_ack = 1'b0; m_valid = 1'b0; m_data = '0;
    test_reset();
    test_single_icache();
    test_tie_after_reset();
    test_alternate();
    test_gaps_long_ack();
    test_proto_err();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
